// File: rtl/dark_channel_prep.sv
// Dark-channel front end for the alpha divider: per-pixel RGB minimum, causal
// 3-tap horizontal minimum, and frame-maximum atmospheric light tracking.
module dark_channel_prep #(
   parameter logic [7:0] A_INIT    = 8'd255,
   parameter logic [7:0] MIN_DENOM = 8'd1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_sol,
   input  logic       in_eof,
   input  logic [7:0] in_r,
   input  logic [7:0] in_g,
   input  logic [7:0] in_b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_dark_diff,
   output logic [7:0] out_denom,
   output logic       out_eof,
   output logic [7:0] atm_light
);

   localparam int unsigned DATA_W = 8;
   localparam logic [DATA_W-1:0] PIX_MAX = '1;
   localparam logic [DATA_W-1:0] A_RST   = (A_INIT > MIN_DENOM) ? A_INIT : MIN_DENOM;

   function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // a - b clamped at zero so the divider numerator never wraps
   function automatic logic [DATA_W-1:0] sat0_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      return (b > a) ? '0 : (a - b);
   endfunction

   logic              adv;
   logic              vld_p1_q, vld_p1_d;
   logic [DATA_W-1:0] m_p1_q, m_p1_d;
   logic              sol_p1_q, sol_p1_d;
   logic              eof_p1_q, eof_p1_d;
   logic [DATA_W-1:0] h1_q, h1_d;
   logic [DATA_W-1:0] h2_q, h2_d;
   logic              vld_p2_q, vld_p2_d;
   logic [DATA_W-1:0] diff_p2_q, diff_p2_d;
   logic [DATA_W-1:0] denom_p2_q, denom_p2_d;
   logic              eof_p2_q, eof_p2_d;
   logic [DATA_W-1:0] atm_q, atm_d;
   logic [DATA_W-1:0] fmax_q, fmax_d;
   logic [DATA_W-1:0] tap1, tap2, win, fmax_upd;

   assign adv           = !vld_p2_q || out_ready;
   assign in_ready      = adv;
   assign out_valid     = vld_p2_q;
   assign out_dark_diff = diff_p2_q;
   assign out_denom     = denom_p2_q;
   assign out_eof       = eof_p2_q;
   assign atm_light     = atm_q;

   always_comb begin
      vld_p1_d   = vld_p1_q;
      m_p1_d     = m_p1_q;
      sol_p1_d   = sol_p1_q;
      eof_p1_d   = eof_p1_q;
      h1_d       = h1_q;
      h2_d       = h2_q;
      vld_p2_d   = vld_p2_q;
      diff_p2_d  = diff_p2_q;
      denom_p2_d = denom_p2_q;
      eof_p2_d   = eof_p2_q;
      atm_d      = atm_q;
      fmax_d     = fmax_q;

      // A line start masks both history taps so the window never crosses lines
      tap1     = sol_p1_q ? PIX_MAX : h1_q;
      tap2     = sol_p1_q ? PIX_MAX : h2_q;
      win      = min2(m_p1_q, min2(tap1, tap2));
      fmax_upd = max2(fmax_q, win);

      if (adv) begin
         // stage 1: per-pixel channel minimum
         vld_p1_d = in_valid;
         if (in_valid) begin
            m_p1_d   = min2(in_r, min2(in_g, in_b));
            sol_p1_d = in_sol;
            eof_p1_d = in_eof;
         end

         // stage 2: horizontal window, output beat, atmospheric light update
         vld_p2_d = vld_p1_q;
         if (vld_p1_q) begin
            h1_d       = m_p1_q;
            h2_d       = tap1;
            diff_p2_d  = sat0_sub(atm_q, win);
            denom_p2_d = atm_q;
            eof_p2_d   = eof_p1_q;
            if (eof_p1_q) begin
               atm_d  = max2(fmax_upd, MIN_DENOM);
               fmax_d = '0;
            end else begin
               fmax_d = fmax_upd;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q   <= 1'b0;
         m_p1_q     <= '0;
         sol_p1_q   <= 1'b0;
         eof_p1_q   <= 1'b0;
         h1_q       <= PIX_MAX;
         h2_q       <= PIX_MAX;
         vld_p2_q   <= 1'b0;
         diff_p2_q  <= '0;
         denom_p2_q <= A_RST;
         eof_p2_q   <= 1'b0;
         atm_q      <= A_RST;
         fmax_q     <= '0;
      end else begin
         vld_p1_q   <= vld_p1_d;
         m_p1_q     <= m_p1_d;
         sol_p1_q   <= sol_p1_d;
         eof_p1_q   <= eof_p1_d;
         h1_q       <= h1_d;
         h2_q       <= h2_d;
         vld_p2_q   <= vld_p2_d;
         diff_p2_q  <= diff_p2_d;
         denom_p2_q <= denom_p2_d;
         eof_p2_q   <= eof_p2_d;
         atm_q      <= atm_d;
         fmax_q     <= fmax_d;
      end
   end

endmodule

// File: tb/tb_dark_channel_prep.sv
// Directed bench for dark_channel_prep: each task drives one scenario and
// compares against hand-computed values.
module tb_dark_channel_prep;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, in_sol, in_eof;
   logic [7:0] in_r, in_g, in_b;
   logic       out_valid, out_ready, out_eof;
   logic [7:0] out_dark_diff, out_denom, atm_light;

   int checks = 0;
   int errors = 0;

   // accepted output beats: {dark_diff, denom, eof}
   logic [16:0] obs_q[$];

   always #5 clk = ~clk;

   dark_channel_prep dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sol       (in_sol),
      .in_eof       (in_eof),
      .in_r         (in_r),
      .in_g         (in_g),
      .in_b         (in_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_dark_diff(out_dark_diff),
      .out_denom    (out_denom),
      .out_eof      (out_eof),
      .atm_light    (atm_light)
   );

   // inputs change just after posedge, so the negedge view is what transfers
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready)
         obs_q.push_back({out_dark_diff, out_denom, out_eof});
   end

   task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic sol, input logic eof);
      logic acc;
      int   n;
      in_valid = 1'b1;
      in_r = r; in_g = g; in_b = b; in_sol = sol; in_eof = eof;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 40) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout in_ready never high after %0d cycles", n);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sol = 1'b0;
      in_eof = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0; in_sol = 1'b0; in_eof = 1'b0;
      in_r = '0; in_g = '0; in_b = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0d exp 0", out_valid); end
      checks++; if (out_dark_diff !== 8'd0) begin errors++; $display("FAIL rst_dark_diff got %0d exp 0", out_dark_diff); end
      checks++; if (out_denom !== 8'd255) begin errors++; $display("FAIL rst_denom got %0d exp 255", out_denom); end
      checks++; if (atm_light !== 8'd255) begin errors++; $display("FAIL rst_atm got %0d exp 255", atm_light); end
      checks++; if (out_eof !== 1'b0) begin errors++; $display("FAIL rst_eof got %0d exp 0", out_eof); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0d exp 1", in_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      obs_q.delete();
      send(8'd200, 8'd50, 8'd90, 1'b1, 1'b0);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 out_valid got %0d exp 0", out_valid); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_lat2 out_valid got %0d exp 1", out_valid); end
      checks++; if (out_dark_diff !== 8'd205) begin errors++; $display("FAIL single_diff got %0d exp 205", out_dark_diff); end
      checks++; if (out_denom !== 8'd255) begin errors++; $display("FAIL single_denom got %0d exp 255", out_denom); end
      idle(3);
      checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", obs_q.size()); end
   endtask

   task automatic test_line;
      logic [7:0] exp_diff [5];
      exp_diff = '{8'd215, 8'd245, 8'd245, 8'd245, 8'd185};
      obs_q.delete();
      send(8'd40, 8'd100, 8'd200, 1'b1, 1'b0);
      send(8'd90, 8'd10, 8'd30, 1'b0, 1'b0);
      send(8'd70, 8'd200, 8'd150, 1'b0, 1'b0);
      send(8'd255, 8'd80, 8'd120, 1'b0, 1'b0);
      send(8'd90, 8'd91, 8'd200, 1'b0, 1'b0);
      idle(4);
      checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL line_count got %0d exp 5", obs_q.size()); end
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i][16:9] !== exp_diff[i] || obs_q[i][8:1] !== 8'd255) begin
            errors++;
            $display("FAIL line_beat%0d got diff %0d denom %0d exp diff %0d denom 255",
                     i, obs_q[i][16:9], obs_q[i][8:1], exp_diff[i]);
         end
      end
   endtask

   task automatic test_atm_frames;
      logic [16:0] exp_beat [4];
      exp_beat = '{{8'd135, 8'd255, 1'b0}, {8'd135, 8'd255, 1'b0},
                   {8'd135, 8'd255, 1'b1}, {8'd60, 8'd120, 1'b1}};
      obs_q.delete();
      send(8'd120, 8'd120, 8'd120, 1'b1, 1'b0);
      send(8'd200, 8'd130, 8'd125, 1'b0, 1'b0);
      send(8'd130, 8'd140, 8'd150, 1'b0, 1'b1);
      send(8'd60, 8'd60, 8'd60, 1'b1, 1'b1);
      idle(4);
      checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL atm_count got %0d exp 4", obs_q.size()); end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_beat[i]) begin
            errors++;
            $display("FAIL atm_beat%0d got diff %0d denom %0d eof %0d exp diff %0d denom %0d eof %0d",
                     i, obs_q[i][16:9], obs_q[i][8:1], obs_q[i][0],
                     exp_beat[i][16:9], exp_beat[i][8:1], exp_beat[i][0]);
         end
      end
      checks++; if (atm_light !== 8'd60) begin errors++; $display("FAIL atm_after_f2 got %0d exp 60", atm_light); end
   endtask

   task automatic test_zero_frame;
      logic [16:0] exp_beat [3];
      exp_beat = '{{8'd60, 8'd60, 1'b0}, {8'd60, 8'd60, 1'b1}, {8'd0, 8'd1, 1'b0}};
      obs_q.delete();
      send(8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
      send(8'd0, 8'd5, 8'd9, 1'b0, 1'b1);
      send(8'd5, 8'd5, 8'd5, 1'b1, 1'b0);
      idle(4);
      checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL zero_count got %0d exp 3", obs_q.size()); end
      for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_beat[i]) begin
            errors++;
            $display("FAIL zero_beat%0d got diff %0d denom %0d eof %0d exp diff %0d denom %0d eof %0d",
                     i, obs_q[i][16:9], obs_q[i][8:1], obs_q[i][0],
                     exp_beat[i][16:9], exp_beat[i][8:1], exp_beat[i][0]);
         end
      end
      checks++; if (atm_light !== 8'd1) begin errors++; $display("FAIL zero_atm got %0d exp 1", atm_light); end
   endtask

   task automatic test_mid_reset;
      send(8'd10, 8'd11, 8'd12, 1'b1, 1'b0);
      send(8'd20, 8'd21, 8'd22, 1'b0, 1'b0);
      send(8'd30, 8'd31, 8'd32, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid got %0d exp 1", out_valid); end
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %0d exp 0", out_valid); end
      checks++; if (out_dark_diff !== 8'd0) begin errors++; $display("FAIL mrst_diff got %0d exp 0", out_dark_diff); end
      checks++; if (atm_light !== 8'd255) begin errors++; $display("FAIL mrst_atm got %0d exp 255", atm_light); end
      checks++; if (out_denom !== 8'd255) begin errors++; $display("FAIL mrst_denom got %0d exp 255", out_denom); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      obs_q.delete();
      send(8'd200, 8'd210, 8'd220, 1'b1, 1'b0);
      idle(4);
      checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL mrst_count got %0d exp 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         checks++;
         if (obs_q[0] !== {8'd55, 8'd255, 1'b0}) begin
            errors++;
            $display("FAIL mrst_beat got diff %0d denom %0d exp diff 55 denom 255",
                     obs_q[0][16:9], obs_q[0][8:1]);
         end
      end
   endtask

   task automatic test_back_to_back_stall;
      logic [7:0] pix_m [8];
      logic [7:0] exp_diff [8];
      pix_m    = '{8'd100, 8'd50, 8'd80, 8'd90, 8'd30, 8'd60, 8'd70, 8'd20};
      exp_diff = '{8'd155, 8'd205, 8'd205, 8'd205, 8'd225, 8'd225, 8'd225, 8'd235};
      obs_q.delete();
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(pix_m[i] + 8'd5, pix_m[i], pix_m[i] + 8'd9, (i == 0), 1'b0);
            in_valid = 1'b0;
         end
         begin
            logic [7:0] d0, n0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            d0 = out_dark_diff;
            n0 = out_denom;
            repeat (5) begin
               @(negedge clk);
               checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0d exp 0", in_ready); end
               checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %0d exp 1", out_valid); end
               checks++;
               if (out_dark_diff !== d0 || out_denom !== n0) begin
                  errors++;
                  $display("FAIL stall_hold got diff %0d denom %0d exp diff %0d denom %0d",
                           out_dark_diff, out_denom, d0, n0);
               end
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      idle(5);
      checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", obs_q.size()); end
      for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i][16:9] !== exp_diff[i] || obs_q[i][8:1] !== 8'd255) begin
            errors++;
            $display("FAIL b2b_beat%0d got diff %0d denom %0d exp diff %0d denom 255",
                     i, obs_q[i][16:9], obs_q[i][8:1], exp_diff[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_line();
      test_atm_frames();
      test_zero_frame();
      test_mid_reset();
      test_back_to_back_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
